flash_arbiter: RTL

Two-port controller sharing the single-port 16 KB flash memory between the instruction-fetch path (read-only) and the data path (read/write). Round-robin arbitration on simultaneous requests, address legality checking, a write-lock input, and one-cycle response return that matches the flash's registered read latency. Sits between the core's fetch and load/store units and the flash macro. One access is issued per cycle, fully pipelined.

---
 rtl/flash_ctrl_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 43 ++++
 rtl/flash_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/flash_ctrl_pkg.sv
// Shared types and helpers for the flash access controller.
//   port_id_t  : identifies the requesting port (fetch or data)
//   rsp_reg_t  : response pipeline register captured at grant time
//   addr_legal : word-aligned and inside the flash window
package flash_ctrl_pkg;

  localparam int FLASH_ADDR_BITS_DEFAULT = 14;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
    logic     is_write;
    logic     err;
  } rsp_reg_t;

  function automatic logic addr_legal(input logic [31:0] addr, input int abits);
    logic [31:0] hi;
    hi = addr >> abits;
    return (hi == 32'd0) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : request vector (bit 0 = fetch, bit 1 = data)
//   gnt[1:0] : one-hot grant, combinational in the request cycle
// On a tie the requester not granted most recently wins. After reset the
// history says DATA, so fetch takes the first tie.
module rr_arbiter2
  import flash_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_t last_grant;

  // Grants are held off while reset is asserted so nothing reaches the
  // flash (in particular no write) during reset.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == PORT_DATA) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_DATA;
    end else if (gnt[0]) begin
      last_grant <= PORT_FETCH;
    end else if (gnt[1]) begin
      last_grant <= PORT_DATA;
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares the single-port flash between instruction fetch (read-only) and
// the data path (read/write). One access per cycle, response one cycle
// after grant to match the flash's registered read.
// Ports:
//   i_req/i_addr -> i_gnt, i_rvalid/i_rdata/i_err        fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid/...     data port
//   write_lock                                           blocks flash writes
//   f_addr/f_wdata/f_we -> flash, f_rdata <- flash       flash macro side
module flash_arbiter
  import flash_ctrl_pkg::*;
#(
  parameter int FLASH_ADDR_BITS = FLASH_ADDR_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  input  logic        write_lock,
  output logic [31:0] f_addr,
  output logic [31:0] f_wdata,
  output logic        f_we,
  input  logic [31:0] f_rdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       i_legal;
  logic       d_legal;
  rsp_reg_t   rsp_d;
  rsp_reg_t   rsp_q;
  logic       rdata_ok;

  assign req = {d_req, i_req};

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign i_gnt = gnt[0];
  assign d_gnt = gnt[1];

  // A locked write is treated like an illegal address: granted, not written.
  assign i_legal = addr_legal(i_addr, FLASH_ADDR_BITS);
  assign d_legal = addr_legal(d_addr, FLASH_ADDR_BITS) && !(d_we && write_lock);

  always_comb begin
    f_addr  = 32'd0;
    f_wdata = 32'd0;
    f_we    = 1'b0;
    if (i_gnt) begin
      f_addr = i_addr;
    end else if (d_gnt) begin
      f_addr  = d_addr;
      f_wdata = d_wdata;
      f_we    = d_we & d_legal;
    end
  end

  always_comb begin
    rsp_d          = '0;
    rsp_d.valid    = i_gnt | d_gnt;
    rsp_d.port     = d_gnt ? PORT_DATA : PORT_FETCH;
    rsp_d.is_write = d_gnt & d_we;
    rsp_d.err      = d_gnt ? !d_legal : (i_gnt & !i_legal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Flash data is only forwarded for a legal read; writes and errors return 0.
  assign rdata_ok = rsp_q.valid & !rsp_q.is_write & !rsp_q.err;

  assign i_rvalid = rsp_q.valid & (rsp_q.port == PORT_FETCH);
  assign d_rvalid = rsp_q.valid & (rsp_q.port == PORT_DATA);
  assign i_rdata  = (i_rvalid && rdata_ok) ? f_rdata : 32'd0;
  assign d_rdata  = (d_rvalid && rdata_ok) ? f_rdata : 32'd0;
  assign i_err    = i_rvalid & rsp_q.err;
  assign d_err    = d_rvalid & rsp_q.err;

endmodule
